// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - SPI mode 0 byte-framing master engine driving an external sck generator
module spi_master_shifter #(
    parameter int DATA_WIDTH      = 8,
    parameter int CS_LEAD_CYCLES  = 2,
    parameter int CS_TRAIL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sck_en,
    input  logic                  sck_in,
    input  logic                  rising_edge,
    input  logic                  falling_edge,
    output logic                  sck,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Terminal counts: a counter cleared on state entry reaches N-1 on the Nth cycle.
    localparam logic [7:0]       LEAD_LAST  = 8'(CS_LEAD_CYCLES - 1);
    localparam logic [7:0]       TRAIL_LAST = 8'(CS_TRAIL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BIT_ONE    = CNT_W'(1);

    logic [2:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q,  tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q,  rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
    logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [7:0]            lead_cnt_q,  lead_cnt_d;
    logic [7:0]            trail_cnt_q, trail_cnt_d;
    logic                  ss_n_q,      ss_n_d;
    logic                  sck_en_q,    sck_en_d;
    logic                  mosi_q,      mosi_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    // Next-state logic: frame sequencing, bit shifting and the start/busy/done handshake.
    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        lead_cnt_d  = lead_cnt_q;
        trail_cnt_d = trail_cnt_q;
        ss_n_d      = ss_n_q;
        sck_en_d    = sck_en_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // First MOSI bit is presented now so it is valid before the first rising sck.
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[DATA_WIDTH-1];
                    ss_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    lead_cnt_d = 8'd0;
                    state_d    = S_LEAD;
                end
            end
            S_LEAD: begin
                if (lead_cnt_q == LEAD_LAST) begin
                    sck_en_d  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end else begin
                    lead_cnt_d = lead_cnt_q + 8'd1;
                end
            end
            S_SHIFT: begin
                // A rising strobe wins over a simultaneous falling strobe.
                if (rising_edge) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
                    bit_cnt_d  = bit_cnt_q + BIT_ONE;
                end else if (falling_edge) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        // sck is low here, so dropping the enable cannot clip a pulse.
                        sck_en_d    = 1'b0;
                        mosi_d      = 1'b0;
                        trail_cnt_d = 8'd0;
                        state_d     = S_TRAIL;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        mosi_d     = tx_shift_q[DATA_WIDTH-2];
                    end
                end
            end
            S_TRAIL: begin
                if (trail_cnt_q == TRAIL_LAST) begin
                    ss_n_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    trail_cnt_d = trail_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            lead_cnt_q  <= 8'd0;
            trail_cnt_q <= 8'd0;
            ss_n_q      <= 1'b1;
            sck_en_q    <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            lead_cnt_q  <= lead_cnt_d;
            trail_cnt_q <= trail_cnt_d;
            ss_n_q      <= ss_n_d;
            sck_en_q    <= sck_en_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sck_en  = sck_en_q;
    assign ss_n    = ss_n_q;
    assign mosi    = mosi_q;
    assign sck     = sck_in;

endmodule

// File: tb/tb_spi_master_shifter.sv
// tb/tb_spi_master_shifter.sv - randomized self-checking bench for spi_master_shifter
module tb_spi_master_shifter;

    localparam int DW      = 8;
    localparam int LEAD    = 2;
    localparam int TRAIL   = 3;
    localparam int B2B_GAP = 2;
    localparam int BUDGET  = 3000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic [DW-1:0] rx_data;
    logic          busy, done, sck_en, sck, ss_n, mosi;

    logic sck_g, re_g, fe_g;
    int   gen_cnt;
    int   half = 4;

    logic          slave_mode = 1'b0;
    logic [DW-1:0] slave_pat = '0;
    int            slave_idx;
    logic [DW-1:0] slave_sh;
    logic          miso_w;

    int            vectors = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rise_cnt = 0;
    int            done_cnt = 0;
    int            sck_viol = 0;
    int            t_ssfall = 0, t_ssrise = 0, t_enrise = 0, t_enfall = 0, gap_last = 0;
    logic [DW-1:0] mosi_bits = '0;
    logic          prev_ss = 1'b1, prev_en = 1'b0;

    spi_master_shifter #(
        .DATA_WIDTH     (DW),
        .CS_LEAD_CYCLES (LEAD),
        .CS_TRAIL_CYCLES(TRAIL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .busy        (busy),
        .done        (done),
        .sck_en      (sck_en),
        .sck_in      (sck_g),
        .rising_edge (re_g),
        .falling_edge(fe_g),
        .sck         (sck),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso_w)
    );

    always #5 clk = ~clk;

    // Serial clock generator: toggles sck every `half` clk cycles while enabled, forced low otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !sck_en) begin
            gen_cnt <= 0; sck_g <= 1'b0; re_g <= 1'b0; fe_g <= 1'b0;
        end else if (gen_cnt == half - 1) begin
            gen_cnt <= 0; sck_g <= ~sck_g; re_g <= ~sck_g; fe_g <= sck_g;
        end else begin
            gen_cnt <= gen_cnt + 1; re_g <= 1'b0; fe_g <= 1'b0;
        end
    end

    // Slave: either loops mosi back or presents slave_pat MSB-first, advancing on each sck fall.
    always @(posedge clk) begin
        if (ss_n !== 1'b0) slave_idx <= 0;
        else if (fe_g) slave_idx <= slave_idx + 1;
    end
    assign slave_sh = slave_pat << slave_idx;
    assign miso_w   = slave_mode ? slave_sh[DW-1] : mosi;

    // Bus monitor: edge timestamps, bits seen by the slave on rising sck, done pulses, sck while deselected.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (prev_ss && !ss_n) begin
                gap_last = cyc - t_ssrise; t_ssfall = cyc; rise_cnt = 0; mosi_bits = '0;
            end
            if (!prev_ss && ss_n) t_ssrise = cyc;
            if (!prev_en && sck_en) t_enrise = cyc;
            if (prev_en && !sck_en) t_enfall = cyc;
            if (!ss_n && re_g) begin
                rise_cnt = rise_cnt + 1; mosi_bits = {mosi_bits[DW-2:0], mosi};
            end
            if (done) done_cnt = done_cnt + 1;
            if (ss_n && sck) sck_viol = sck_viol + 1;
        end
        prev_ss = ss_n;
        prev_en = sck_en;
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_rises(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(negedge clk); #1;
            if (rise_cnt >= n && ss_n === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic pulse_start(input logic [DW-1:0] tx);
        tx_data = tx;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        tx_data = ~tx;
    endtask

    // One complete frame checked against the reference: mosi carries tx, rx_data gets the slave word.
    task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] pat, input bit mode,
                             input int hp, input string tag);
        bit            ok;
        int            d0;
        logic [DW-1:0] exp_rx;
        half = hp; slave_mode = mode; slave_pat = pat; d0 = done_cnt;
        exp_rx = mode ? pat : tx;
        pulse_start(tx);
        wait_done(ok);
        vectors++; if (!ok) begin errors++; $display("FAIL %s done_timeout got none exp pulse", tag); end
        if (ok) begin
            vectors++; if (rx_data !== exp_rx) begin errors++; $display("FAIL %s rx_data got %h exp %h", tag, rx_data, exp_rx); end
            vectors++; if (mosi_bits !== tx) begin errors++; $display("FAIL %s mosi_bits got %h exp %h", tag, mosi_bits, tx); end
            vectors++; if (rise_cnt !== DW) begin errors++; $display("FAIL %s rise_cnt got %0d exp %0d", tag, rise_cnt, DW); end
            vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_at_done got %b exp 1", tag, busy); end
            vectors++; if (t_enrise - t_ssfall !== LEAD) begin errors++; $display("FAIL %s lead got %0d exp %0d", tag, t_enrise - t_ssfall, LEAD); end
            vectors++; if (t_ssrise - t_enfall !== TRAIL) begin errors++; $display("FAIL %s trail got %0d exp %0d", tag, t_ssrise - t_enfall, TRAIL); end
            vectors++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", tag, done_cnt - d0); end
            vectors++; if (sck_viol !== 0) begin errors++; $display("FAIL %s sck_deselected got %0d exp 0", tag, sck_viol); end
            @(negedge clk); #1;
            vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s after_done busy/done got %b%b exp 00", tag, busy, done); end
        end
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        vectors++; if (ss_n !== 1'b1 || sck_en !== 1'b0 || mosi !== 1'b0) begin errors++; $display("FAIL reset ss_n/sck_en/mosi got %b%b%b exp 100", ss_n, sck_en, mosi); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset busy/done got %b%b exp 00", busy, done); end
        vectors++; if (rx_data !== '0) begin errors++; $display("FAIL reset rx_data got %h exp 00", rx_data); end
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback;
        run_frame(8'hA5, 8'h00, 1'b0, 32, "loopback");
    endtask

    task automatic test_fixed_slave;
        run_frame(8'hFF, 8'h3C, 1'b1, 4, "fixed_slave");
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++)
            run_frame(DW'($urandom), DW'($urandom), 1'($urandom), int'($urandom_range(2, 8)), "random");
    endtask

    task automatic test_start_while_busy;
        bit            ok;
        int            d0;
        logic [DW-1:0] tx;
        tx = DW'($urandom) | 8'h01;
        half = 4; slave_mode = 1'b0; d0 = done_cnt;
        pulse_start(tx);
        wait_rises(4, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL busy_start rise_timeout got none exp 4 rises"); end
        pulse_start(8'h00);
        tx_data = 8'h00;
        wait_done(ok);
        vectors++; if (!ok) begin errors++; $display("FAIL busy_start done_timeout got none exp pulse"); end
        vectors++; if (rx_data !== tx) begin errors++; $display("FAIL busy_start rx_data got %h exp %h", rx_data, tx); end
        vectors++; if (mosi_bits !== tx) begin errors++; $display("FAIL busy_start mosi_bits got %h exp %h", mosi_bits, tx); end
        repeat (20) @(negedge clk);
        #1;
        vectors++; if (ss_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL busy_start queued ss_n/busy got %b%b exp 10", ss_n, busy); end
        vectors++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_start done_count got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int d0;
        half = 2; slave_mode = 1'b0; tx_data = 8'h81;
        @(negedge clk); #1 start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d0 = done_cnt;
            wait_done(ok);
            vectors++; if (!ok) begin errors++; $display("FAIL b2b done_timeout frame %0d got none exp pulse", k); end
            vectors++; if (rx_data !== 8'h81) begin errors++; $display("FAIL b2b rx_data frame %0d got %h exp 81", k, rx_data); end
            vectors++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b done_count frame %0d got %0d exp 1", k, done_cnt - d0); end
            if (k > 0) begin
                vectors++; if (gap_last !== B2B_GAP) begin errors++; $display("FAIL b2b ss_gap frame %0d got %0d exp %0d", k, gap_last, B2B_GAP); end
            end
            if (k == 2) start = 1'b0;
        end
        repeat (6) @(negedge clk);
        #1;
        vectors++; if (ss_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b idle ss_n/busy got %b%b exp 10", ss_n, busy); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d0;
        half = 3; slave_mode = 1'b0; d0 = done_cnt;
        pulse_start(8'h5A);
        wait_rises(3, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL rst_mid rise_timeout got none exp 3 rises"); end
        rst_n = 1'b0;
        #1;
        vectors++; if (ss_n !== 1'b1 || sck_en !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid ss_n/sck_en/mosi/busy got %b%b%b%b exp 1000", ss_n, sck_en, mosi, busy);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        vectors++; if (done_cnt !== d0 || ss_n !== 1'b1) begin errors++; $display("FAIL rst_mid no_done done_count/ss_n got %0d/%b exp %0d/1", done_cnt - d0, ss_n, 0); end
        run_frame(DW'($urandom), DW'($urandom), 1'b1, 4, "after_reset");
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_fixed_slave;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
